// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the MIPS pipeline sequencing controller.
// Forwarding-select codes and write-back source codes match the datapath muxes.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_NO      = 2'd0;
    localparam logic [1:0] FWD_ALU_EXE = 2'd1;
    localparam logic [1:0] FWD_WB_MEM  = 2'd2;
    localparam logic [1:0] FWD_MEM     = 2'd3;

    localparam logic WB_DATA_ALU = 1'b0;
    localparam logic WB_DATA_MEM = 1'b1;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_JR     = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    // Branch sequencing: RUN -> BR_EXE -> BR_MEM -> RUN, resolving in MEM.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BR_EXE = 2'd1,
        ST_BR_MEM = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand producer compare: picks the youngest matching producer (EXE, MEM, WB)
// and flags the case where only the WB producer matches.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] addr,
    input  logic       used,
    input  logic [4:0] exe_addr,
    input  logic       exe_wen,
    input  logic       exe_src,
    input  logic [4:0] mem_addr,
    input  logic       mem_wen,
    input  logic [4:0] wb_addr,
    input  logic       wb_wen,
    output logic [1:0] sel,
    output logic       wb_only
);

    logic qual;
    logic hit_exe;
    logic hit_mem;
    logic hit_wb;

    // $0 is hard-wired zero, so a write to it never produces a dependency.
    assign qual    = used && (addr != 5'd0);
    assign hit_exe = qual && exe_wen && (exe_addr == addr);
    assign hit_mem = qual && mem_wen && (mem_addr == addr);
    assign hit_wb  = qual && wb_wen  && (wb_addr  == addr);

    always_comb begin
        sel     = FWD_NO;
        wb_only = 1'b0;
        if (hit_exe) begin
            sel = (exe_src == WB_DATA_MEM) ? FWD_MEM : FWD_ALU_EXE;
        end else if (hit_mem) begin
            sel = FWD_WB_MEM;
        end else if (hit_wb) begin
            wb_only = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: forwarding selects, RAW stall, 3-bubble branch
// sequence, data-memory freeze, and saturating stall/flush debug counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REGFILE_BYPASS = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_branch_id,
    input  logic [4:0]       addr_rs,
    input  logic [4:0]       addr_rt,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic [4:0]       regw_addr_exe,
    input  logic             wb_wen_exe,
    input  logic             wb_data_src_exe,
    input  logic [4:0]       regw_addr_mem,
    input  logic             wb_wen_mem,
    input  logic             wb_data_src_mem,
    input  logic [4:0]       regw_addr_wb,
    input  logic             wb_wen_wb,
    input  logic             mem_access_mem,
    input  logic             mem_ready,
    output logic             if_rst,
    output logic             if_en,
    output logic             id_rst,
    output logic             id_en,
    output logic             exe_rst,
    output logic             exe_en,
    output logic             mem_rst,
    output logic             mem_en,
    output logic             wb_rst,
    output logic             wb_en,
    output logic [1:0]       exe_fwd_a_ctrl,
    output logic [1:0]       exe_fwd_b_ctrl,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       fsm_state
);

    state_t     state;
    state_t     state_next;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       wb_only_a;
    logic       wb_only_b;
    logic       mem_wait;
    logic       data_stall;
    logic       stall_inc;
    logic       flush_inc;

    fwd_sel u_fwd_a (
        .addr     (addr_rs),
        .used     (rs_used),
        .exe_addr (regw_addr_exe),
        .exe_wen  (wb_wen_exe),
        .exe_src  (wb_data_src_exe),
        .mem_addr (regw_addr_mem),
        .mem_wen  (wb_wen_mem),
        .wb_addr  (regw_addr_wb),
        .wb_wen   (wb_wen_wb),
        .sel      (sel_a),
        .wb_only  (wb_only_a)
    );

    fwd_sel u_fwd_b (
        .addr     (addr_rt),
        .used     (rt_used),
        .exe_addr (regw_addr_exe),
        .exe_wen  (wb_wen_exe),
        .exe_src  (wb_data_src_exe),
        .mem_addr (regw_addr_mem),
        .mem_wen  (wb_wen_mem),
        .wb_addr  (regw_addr_wb),
        .wb_wen   (wb_wen_wb),
        .sel      (sel_b),
        .wb_only  (wb_only_b)
    );

    assign mem_wait   = mem_access_mem && !mem_ready;
    assign data_stall = (REGFILE_BYPASS == 0) && (wb_only_a || wb_only_b) && (state == ST_RUN);

    assign exe_fwd_a_ctrl = rst ? FWD_NO : sel_a;
    assign exe_fwd_b_ctrl = rst ? FWD_NO : sel_b;
    assign fsm_state      = state;

    always_comb begin
        if_rst     = 1'b0;
        id_rst     = 1'b0;
        exe_rst    = 1'b0;
        mem_rst    = 1'b0;
        wb_rst     = 1'b0;
        if_en      = 1'b1;
        id_en      = 1'b1;
        exe_en     = 1'b1;
        mem_en     = 1'b1;
        wb_en      = 1'b1;
        state_next = state;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (rst) begin
            if_rst     = 1'b1;
            id_rst     = 1'b1;
            exe_rst    = 1'b1;
            mem_rst    = 1'b1;
            wb_rst     = 1'b1;
            if_en      = 1'b0;
            id_en      = 1'b0;
            exe_en     = 1'b0;
            mem_en     = 1'b0;
            wb_en      = 1'b0;
            state_next = ST_RUN;
        end else if (mem_wait) begin
            // Freeze everything up to MEM and push a bubble into WB; branch state holds.
            if_en     = 1'b0;
            id_en     = 1'b0;
            exe_en    = 1'b0;
            mem_en    = 1'b0;
            wb_rst    = 1'b1;
            stall_inc = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (data_stall) begin
                        if_en     = 1'b0;
                        id_en     = 1'b0;
                        exe_rst   = 1'b1;
                        stall_inc = 1'b1;
                    end else if (is_branch_id) begin
                        if_en      = 1'b0;
                        id_rst     = 1'b1;
                        flush_inc  = 1'b1;
                        state_next = ST_BR_EXE;
                    end
                end
                ST_BR_EXE: begin
                    if_en      = 1'b0;
                    id_rst     = 1'b1;
                    flush_inc  = 1'b1;
                    state_next = ST_BR_MEM;
                end
                ST_BR_MEM: begin
                    // Branch resolves in MEM: PC loads the target while ID is still flushed.
                    id_rst     = 1'b1;
                    flush_inc  = 1'b1;
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance and a write-through-regfile
// instance with 2-bit counters share one stimulus stream.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       is_branch_id;
    logic [4:0] addr_rs;
    logic [4:0] addr_rt;
    logic       rs_used;
    logic       rt_used;
    logic [4:0] regw_addr_exe;
    logic       wb_wen_exe;
    logic       wb_data_src_exe;
    logic [4:0] regw_addr_mem;
    logic       wb_wen_mem;
    logic       wb_data_src_mem;
    logic [4:0] regw_addr_wb;
    logic       wb_wen_wb;
    logic       mem_access_mem;
    logic       mem_ready;

    logic        if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
    logic [1:0]  fwd_a, fwd_b, state_a;
    logic [15:0] stall_cnt, flush_cnt;

    logic        if_rst_b, if_en_b, id_rst_b, id_en_b, exe_rst_b, exe_en_b;
    logic        mem_rst_b, mem_en_b, wb_rst_b, wb_en_b;
    logic [1:0]  fwd_a_b, fwd_b_b, state_b;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    int checks = 0;
    int errors = 0;

    logic br_exe = 1'b0;
    logic br_mem = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REGFILE_BYPASS(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .is_branch_id(is_branch_id),
        .addr_rs(addr_rs), .addr_rt(addr_rt), .rs_used(rs_used), .rt_used(rt_used),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .wb_data_src_exe(wb_data_src_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .wb_data_src_mem(wb_data_src_mem),
        .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
        .mem_access_mem(mem_access_mem), .mem_ready(mem_ready),
        .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
        .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
        .wb_rst(wb_rst), .wb_en(wb_en),
        .exe_fwd_a_ctrl(fwd_a), .exe_fwd_b_ctrl(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fsm_state(state_a)
    );

    hazard_ctrl #(.REGFILE_BYPASS(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .is_branch_id(is_branch_id),
        .addr_rs(addr_rs), .addr_rt(addr_rt), .rs_used(rs_used), .rt_used(rt_used),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .wb_data_src_exe(wb_data_src_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .wb_data_src_mem(wb_data_src_mem),
        .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
        .mem_access_mem(mem_access_mem), .mem_ready(mem_ready),
        .if_rst(if_rst_b), .if_en(if_en_b), .id_rst(id_rst_b), .id_en(id_en_b),
        .exe_rst(exe_rst_b), .exe_en(exe_en_b), .mem_rst(mem_rst_b), .mem_en(mem_en_b),
        .wb_rst(wb_rst_b), .wb_en(wb_en_b),
        .exe_fwd_a_ctrl(fwd_a_b), .exe_fwd_b_ctrl(fwd_b_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .fsm_state(state_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        is_branch_id    = 1'b0;
        addr_rs         = 5'd0;
        addr_rt         = 5'd0;
        rs_used         = 1'b0;
        rt_used         = 1'b0;
        regw_addr_exe   = 5'd0;
        wb_wen_exe      = 1'b0;
        wb_data_src_exe = WB_DATA_ALU;
        regw_addr_mem   = 5'd0;
        wb_wen_mem      = 1'b0;
        wb_data_src_mem = WB_DATA_ALU;
        regw_addr_wb    = 5'd0;
        wb_wen_wb       = 1'b0;
        mem_access_mem  = 1'b0;
        mem_ready       = 1'b1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Stage-control vectors, ordered IF, ID, EXE, MEM, WB.
    function automatic logic [4:0] rsts_a();
        return {if_rst, id_rst, exe_rst, mem_rst, wb_rst};
    endfunction
    function automatic logic [4:0] ens_a();
        return {if_en, id_en, exe_en, mem_en, wb_en};
    endfunction
    function automatic logic [4:0] rsts_b();
        return {if_rst_b, id_rst_b, exe_rst_b, mem_rst_b, wb_rst_b};
    endfunction
    function automatic logic [4:0] ens_b();
        return {if_en_b, id_en_b, exe_en_b, mem_en_b, wb_en_b};
    endfunction

    // Datapath-side branch flags in EXE/MEM must track BR_EXE/BR_MEM of the main instance.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            br_exe = 1'b0;
            br_mem = 1'b0;
        end else if (rst === 1'b0) begin
            chk("br_exe_agree", {31'd0, state_a == ST_BR_EXE}, {31'd0, br_exe});
            chk("br_mem_agree", {31'd0, state_a == ST_BR_MEM}, {31'd0, br_mem});
            if (mem_rst) br_mem = 1'b0;
            else if (mem_en) br_mem = br_exe;
            if (exe_rst) br_exe = 1'b0;
            else if (exe_en) br_exe = is_branch_id;
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        // Reset with a live EXE match: forwarding must still read FWD_NO.
        regw_addr_exe = 5'd1; wb_wen_exe = 1'b1; addr_rs = 5'd1; rs_used = 1'b1;
        @(negedge clk);
        chk("rst_rsts", rsts_a(), 5'b11111);
        chk("rst_ens", ens_a(), 5'b00000);
        chk("rst_fwd_a", fwd_a, FWD_NO);
        chk("rst_fwd_b", fwd_b, FWD_NO);
        adv();
        adv();
        rst = 1'b0;
        clr();

        // T1 idle RUN
        @(negedge clk);
        chk("t1_rsts", rsts_a(), 5'b00000);
        chk("t1_ens", ens_a(), 5'b11111);
        chk("t1_stall", stall_cnt, 0);
        chk("t1_flush", flush_cnt, 0);
        chk("t1_state", state_a, ST_RUN);
        adv();

        // T2 add $1 in EXE, sub $2,$1,$3 in ID
        clr();
        regw_addr_exe = 5'd1; wb_wen_exe = 1'b1; wb_data_src_exe = WB_DATA_ALU;
        addr_rs = 5'd1; rs_used = 1'b1; addr_rt = 5'd3; rt_used = 1'b1;
        @(negedge clk);
        chk("alu_fwd_a", fwd_a, FWD_ALU_EXE);
        chk("alu_fwd_b", fwd_b, FWD_NO);
        chk("alu_ens", ens_a(), 5'b11111);
        adv();

        // T3 lw $4 in EXE (MEM also writes $4), add $5,$4,$4 in ID
        clr();
        regw_addr_exe = 5'd4; wb_wen_exe = 1'b1; wb_data_src_exe = WB_DATA_MEM;
        regw_addr_mem = 5'd4; wb_wen_mem = 1'b1;
        addr_rs = 5'd4; rs_used = 1'b1; addr_rt = 5'd4; rt_used = 1'b1;
        @(negedge clk);
        chk("lw_fwd_a", fwd_a, FWD_MEM);
        chk("lw_fwd_b", fwd_b, FWD_MEM);
        chk("lw_ens", ens_a(), 5'b11111);
        adv();

        // T4 MEM and WB both write $7: MEM wins; rt matches WB but is unused
        clr();
        regw_addr_mem = 5'd7; wb_wen_mem = 1'b1;
        regw_addr_wb = 5'd7; wb_wen_wb = 1'b1;
        addr_rs = 5'd7; rs_used = 1'b1; addr_rt = 5'd7; rt_used = 1'b0;
        @(negedge clk);
        chk("mem_fwd_a", fwd_a, FWD_WB_MEM);
        chk("unused_fwd_b", fwd_b, FWD_NO);
        chk("mem_ens", ens_a(), 5'b11111);
        chk("mem_stall", stall_cnt, 0);
        adv();

        // T5 EXE writes $0 while ID reads $0
        clr();
        regw_addr_exe = 5'd0; wb_wen_exe = 1'b1;
        addr_rs = 5'd0; rs_used = 1'b1; addr_rt = 5'd0; rt_used = 1'b1;
        @(negedge clk);
        chk("r0_fwd_a", fwd_a, FWD_NO);
        chk("r0_fwd_b", fwd_b, FWD_NO);
        adv();

        // T6 producer of $6 in WB only
        clr();
        regw_addr_wb = 5'd6; wb_wen_wb = 1'b1; addr_rs = 5'd6; rs_used = 1'b1;
        @(negedge clk);
        chk("wb_stall_ens", ens_a(), 5'b00111);
        chk("wb_stall_rsts", rsts_a(), 5'b00100);
        chk("wb_stall_fwd_a", fwd_a, FWD_NO);
        chk("bypass_ens", ens_b(), 5'b11111);
        chk("bypass_rsts", rsts_b(), 5'b00000);
        adv();

        // T7 producer retired
        clr();
        addr_rs = 5'd6; rs_used = 1'b1;
        @(negedge clk);
        chk("after_stall_cnt", stall_cnt, 1);
        chk("after_stall_ens", ens_a(), 5'b11111);
        chk("bypass_stall_cnt", stall_cnt_b, 0);
        adv();

        // T8 branch in ID together with WB-only dependency: stall wins (bypass instance branches)
        clr();
        is_branch_id = 1'b1;
        regw_addr_wb = 5'd6; wb_wen_wb = 1'b1; addr_rs = 5'd6; rs_used = 1'b1;
        @(negedge clk);
        chk("br_stall_ens", ens_a(), 5'b00111);
        chk("br_stall_rsts", rsts_a(), 5'b00100);
        chk("b_branch_rsts", rsts_b(), 5'b01000);
        chk("b_branch_ens", ens_b(), 5'b01111);
        adv();

        // T9 branch proceeds
        clr();
        is_branch_id = 1'b1;
        @(negedge clk);
        chk("br_run_state", state_a, ST_RUN);
        chk("br_run_stall", stall_cnt, 2);
        chk("br_run_rsts", rsts_a(), 5'b01000);
        chk("br_run_ens", ens_a(), 5'b01111);
        chk("b_br_exe_state", state_b, ST_BR_EXE);
        adv();

        // T10 BR_EXE
        clr();
        @(negedge clk);
        chk("br_exe_state", state_a, ST_BR_EXE);
        chk("br_exe_rsts", rsts_a(), 5'b01000);
        chk("br_exe_ens", ens_a(), 5'b01111);
        chk("b_br_mem_state", state_b, ST_BR_MEM);
        chk("b_br_mem_ens", ens_b(), 5'b11111);
        adv();

        // T11 BR_MEM
        @(negedge clk);
        chk("br_mem_state", state_a, ST_BR_MEM);
        chk("br_mem_rsts", rsts_a(), 5'b01000);
        chk("br_mem_ens", ens_a(), 5'b11111);
        chk("b_back_run", state_b, ST_RUN);
        adv();

        // T12 back in RUN; second branch starts on both instances
        is_branch_id = 1'b1;
        @(negedge clk);
        chk("br_done_state", state_a, ST_RUN);
        chk("br_done_flush", flush_cnt, 3);
        chk("b_flush3", flush_cnt_b, 3);
        chk("br2_rsts", rsts_a(), 5'b01000);
        adv();

        // T13..T16 store in MEM, memory not ready for 4 cycles during BR_EXE
        clr();
        mem_access_mem = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_state", state_a, ST_BR_EXE);
            chk("wait_ens", ens_a(), 5'b00001);
            chk("wait_rsts", rsts_a(), 5'b00001);
            chk("wait_stall", stall_cnt, 2 + i);
            chk("wait_flush", flush_cnt, 4);
            chk("b_flush_sat", flush_cnt_b, 3);
            adv();
        end

        // T17 memory completes: pipeline advances out of BR_EXE
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wdone_stall", stall_cnt, 6);
        chk("wdone_state", state_a, ST_BR_EXE);
        chk("wdone_ens", ens_a(), 5'b01111);
        chk("b_stall_sat", stall_cnt_b, 3);
        adv();
        clr();

        // T18 BR_MEM, T19 RUN with a new branch
        @(negedge clk);
        chk("t18_state", state_a, ST_BR_MEM);
        adv();
        is_branch_id = 1'b1;
        @(negedge clk);
        chk("t19_state", state_a, ST_RUN);
        chk("t19_flush", flush_cnt, 6);
        adv();

        // T20 memory wait in BR_EXE, T21 reset arrives mid-wait
        clr();
        mem_access_mem = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("t20_state", state_a, ST_BR_EXE);
        chk("t20_stall", stall_cnt, 6);
        chk("t20_flush", flush_cnt, 7);
        adv();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsts", rsts_a(), 5'b11111);
        chk("midrst_ens", ens_a(), 5'b00000);
        adv();
        rst = 1'b0;
        clr();
        @(negedge clk);
        chk("postrst_state", state_a, ST_RUN);
        chk("postrst_stall", stall_cnt, 0);
        chk("postrst_flush", flush_cnt, 0);
        chk("postrst_ens", ens_a(), 5'b11111);
        chk("b_postrst_state", state_b, ST_RUN);
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
